// File: rtl/sram_bist.sv
// sram_bist: write/readback BIST that sweeps an SRAM controller with an addr^SEED pattern
module sram_bist #(
    parameter logic [14:0] ADDR_LAST = 15'h7FFF,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter int          TXN_WAIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        sram_wreq,
    output logic [14:0] sram_waddr,
    output logic [7:0]  sram_wdata,
    output logic        sram_rreq,
    output logic [14:0] sram_raddr,
    input  logic [7:0]  sram_rdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [14:0] first_err_addr
);
    typedef enum logic [2:0] {IDLE, WREQ, WWAIT, RREQ, RWAIT, CHECK, DONE} state_t;
    state_t state, state_nx;
    logic [14:0] addr, addr_nx;
    logic [3:0]  wcnt, wcnt_nx;
    logic [15:0] err_nx;
    logic        last, wdone, mis;
    assign last      = addr == ADDR_LAST;
    assign wdone     = wcnt == 4'(TXN_WAIT - 1);
    assign mis       = sram_rdata != (addr[7:0] ^ SEED);
    assign err_nx    = (mis && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
    assign sram_wreq = state == WREQ;
    assign sram_rreq = state == RREQ;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: begin
                state_nx = start ? WREQ : IDLE;
                addr_nx  = start ? 15'd0 : addr;
            end
            WREQ: begin
                state_nx = WWAIT;
                wcnt_nx  = 4'd0;
            end
            WWAIT: begin
                wcnt_nx  = wcnt + 4'd1;
                state_nx = !wdone ? WWAIT : last ? RREQ : WREQ;
                addr_nx  = !wdone ? addr : last ? 15'd0 : addr + 15'd1;
            end
            RREQ: begin
                state_nx = RWAIT;
                wcnt_nx  = 4'd0;
            end
            RWAIT: begin
                wcnt_nx  = wcnt + 4'd1;
                state_nx = wdone ? CHECK : RWAIT;
            end
            CHECK: begin
                state_nx = last ? DONE : RREQ;
                addr_nx  = last ? addr : addr + 15'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // request buses are loaded on entry so they hold steady for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            addr           <= '0;
            wcnt           <= '0;
            sram_waddr     <= '0;
            sram_wdata     <= '0;
            sram_raddr     <= '0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
        end else begin
            addr <= addr_nx;
            wcnt <= wcnt_nx;
            if (state_nx == WREQ) begin
                sram_waddr <= addr_nx;
                sram_wdata <= addr_nx[7:0] ^ SEED;
            end
            if (state_nx == RREQ) sram_raddr <= addr_nx;
            if (state == IDLE && start) begin
                err_cnt        <= '0;
                first_err_addr <= '0;
                pass           <= 1'b0;
            end
            if (state == CHECK) begin
                err_cnt <= err_nx;
                if (mis && err_cnt == 16'd0) first_err_addr <= addr;
                if (last) pass <= err_nx == 16'd0;
            end
        end
    end
endmodule

// File: doc/sram_bist.md
SRAM_BIST -- requirements
Module: sram_bist

Interface
REQ-001 The block SHALL have parameter ADDR_LAST, default 15'h7FFF, meaning the last address tested; the sweep covers 0..ADDR_LAST.
REQ-002 The block SHALL have parameter SEED, default 8'hA5, meaning the data pattern key; the expected byte is addr[7:0] XOR SEED.
REQ-003 The block SHALL have parameter TXN_WAIT, default 8, range 6..15, meaning the wait cycles after each request; it covers the controller's 6-cycle transaction.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle request to run a full write/readback sweep.
REQ-007 The block SHALL have port sram_wreq, output, 1 bit: write request to the SRAM controller.
REQ-008 The block SHALL have port sram_waddr, output, 15 bits: write address.
REQ-009 The block SHALL have port sram_wdata, output, 8 bits: write data.
REQ-010 The block SHALL have port sram_rreq, output, 1 bit: read request to the SRAM controller.
REQ-011 The block SHALL have port sram_raddr, output, 15 bits: read address.
REQ-012 The block SHALL have port sram_rdata, input, 8 bits: read data returned by the controller.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a sweep.
REQ-015 The block SHALL have port pass, output, 1 bit: 1 when the last sweep completed with zero mismatches.
REQ-016 The block SHALL have port err_cnt, output, 16 bits: mismatch count for the current or last sweep.
REQ-017 The block SHALL have port first_err_addr, output, 15 bits: address of the first mismatch.

Function
REQ-018 The FSM SHALL have states IDLE, WREQ, WWAIT, RREQ, RWAIT, CHECK, DONE, with an internal 15-bit address counter addr and a 4-bit wait counter wcnt.
REQ-019 In IDLE with start=1, the block SHALL set addr=0, err_cnt=0, first_err_addr=0 and pass=0, then go to WREQ; start SHALL be ignored in every other state.
REQ-020 In WREQ, sram_wreq=1 for exactly one cycle, with sram_waddr=addr and sram_wdata=addr[7:0]^SEED; the next state SHALL be WWAIT with wcnt=0.
REQ-021 In WWAIT, wcnt SHALL increment each cycle; on wcnt==TXN_WAIT-1 the block SHALL go to RREQ with addr=0 if addr==ADDR_LAST, otherwise increment addr and go to WREQ.
REQ-022 sram_waddr and sram_wdata SHALL stay stable from WREQ through the end of WWAIT, because the controller holds the write bus for 4+ cycles.
REQ-023 In RREQ, sram_rreq=1 for exactly one cycle with sram_raddr=addr; the next state SHALL be RWAIT with wcnt=0; sram_raddr SHALL stay stable through CHECK.
REQ-024 In RWAIT, on wcnt==TXN_WAIT-1 the block SHALL go to CHECK.
REQ-025 In CHECK, the block SHALL compare sram_rdata against addr[7:0]^SEED.
REQ-026 On a mismatch, err_cnt SHALL increment and saturate at 16'hFFFF.
REQ-027 When err_cnt==0 at a mismatch, first_err_addr SHALL be set to addr.
REQ-028 After CHECK, the block SHALL go to DONE if addr==ADDR_LAST; otherwise it SHALL increment addr and go to RREQ.
REQ-029 In DONE, done=1 for one cycle and pass=(err_cnt==0), where err_cnt includes the final CHECK update; the next state SHALL be IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 sram_wreq and sram_rreq SHALL never be high in the same cycle.
REQ-032 pass, err_cnt and first_err_addr SHALL hold their values in IDLE until the next accepted start.
REQ-033 Latency: with start sampled in IDLE at cycle 0, done SHALL assert at cycle 1+(2*TXN_WAIT+3)*(ADDR_LAST+1).
REQ-034 All outputs SHALL be registered or decoded from registered state only; there SHALL be no combinational path from sram_rdata to any output.
REQ-035 An illegal state code SHALL return the FSM to IDLE on the next clock.

Reset
REQ-036 While rst=1 at a clock edge, the state SHALL go to IDLE and addr, wcnt, sram_waddr, sram_raddr, sram_wdata, err_cnt, first_err_addr, pass, done, busy, sram_wreq and sram_rreq SHALL all clear to 0.
REQ-037 A reset asserted mid-sweep SHALL abort the sweep immediately, with no further requests; a new start SHALL be required afterward.

Verification
REQ-038 Good-memory sweep: ADDR_LAST=3, TXN_WAIT=8, ideal SRAM model behind the controller, start at cycle 0 -> wreq pulses at addr 0..3 with data A5,A4,A7,A6; then rreq 0..3; done at cycle 77; pass=1; err_cnt=0.
REQ-039 Stuck-at-bit fault: model bit0 of addr 2 stuck at 0 -> err_cnt=1, first_err_addr=2, pass=0.
REQ-040 Multiple faults: data corrupted at addr 1 and 3 -> err_cnt=2, first_err_addr=1.
REQ-041 Start while busy: pulse start at cycle 20 -> no restart; done still at cycle 77; counters unaffected.
REQ-042 Reset mid-sweep: rst=1 at cycle 40 for 1 cycle -> all outputs 0 next cycle; no wreq/rreq until a new start; the rerun passes.
REQ-043 Protocol checks: sram_wreq and sram_rreq are each high for one cycle only, never both in the same cycle, and the request spacing is TXN_WAIT+1 cycles for writes and TXN_WAIT+2 cycles for reads.
